// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs and
// architectural status values used by the write-back slice.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;   // rrmovq / cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_t;

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: NREG x DW storage, two combinational read
// ports (RNONE reads as zero) and two synchronous write ports where the
// M port overrides the E port when both target the same register.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int DW   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    srcA,
    input  logic [3:0]    srcB,
    output logic [DW-1:0] valA,
    output logic [DW-1:0] valB,
    input  logic          weE,
    input  logic [3:0]    dstE,
    input  logic [DW-1:0] valE,
    input  logic          weM,
    input  logic [3:0]    dstM,
    input  logic [DW-1:0] valM
);

    logic [DW-1:0] regs [NREG];

    // Read ports: plain array lookup, RNONE yields zero, no write bypass.
    always_comb begin
        valA = {DW{1'b0}};
        valB = {DW{1'b0}};
        if (srcA != RNONE) begin
            valA = regs[srcA];
        end else begin
            valA = {DW{1'b0}};
        end
        if (srcB != RNONE) begin
            valB = regs[srcB];
        end else begin
            valB = {DW{1'b0}};
        end
    end

    // Storage update: reset clears everything; the M write is issued last so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= {DW{1'b0}};
            end
        end else begin
            if (weE && (dstE != RNONE)) begin
                regs[dstE] <= valE;
            end
            if (weM && (dstM != RNONE)) begin
                regs[dstM] <= valM;
            end
        end
    end

endmodule

// File: rtl/y86_writeback_regfile.sv
// Write-back stage of the sequential Y86-64 datapath: destination selection,
// sticky architectural status, retired-instruction counter and the register
// file whose read ports feed Decode.
module y86_writeback_regfile
    import y86_pkg::*;
#(
    parameter int NREG = 15,
    parameter int DW   = 64,
    parameter int CW   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [3:0]    icode,
    input  logic [3:0]    ifun,
    input  logic [3:0]    rA,
    input  logic [3:0]    rB,
    input  logic          cnd,
    input  logic [DW-1:0] valE,
    input  logic [DW-1:0] valM,
    input  logic          imem_error,
    input  logic          dmem_error,
    input  logic [3:0]    srcA,
    input  logic [3:0]    srcB,
    output logic [DW-1:0] valA,
    output logic [DW-1:0] valB,
    output logic [2:0]    stat,
    output logic          halted,
    output logic [CW-1:0] retired
);

    stat_t         statR;
    stat_t         statNext;
    logic          haltedR;
    logic [CW-1:0] retiredR;
    logic [3:0]    dstE;
    logic [3:0]    dstM;
    logic          weE;
    logic          weM;
    logic          incRetire;
    logic [3:0]    ifunUnused;

    // ifun only distinguishes variants whose effect is already folded into cnd/valE.
    assign ifunUnused = ifun;

    // Destination register selection from the instruction fields.
    always_comb begin
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOVQ: begin
                dstE = cnd ? rB : RNONE;
                dstM = RNONE;
            end
            I_IRMOVQ, I_OPQ: begin
                dstE = rB;
                dstM = RNONE;
            end
            I_CALL, I_RET, I_PUSHQ: begin
                dstE = RSP;
                dstM = RNONE;
            end
            I_POPQ: begin
                dstE = RSP;
                dstM = rA;
            end
            I_MRMOVQ: begin
                dstE = RNONE;
                dstM = rA;
            end
            default: begin
                dstE = RNONE;
                dstM = RNONE;
            end
        endcase
    end

    // Commit decision: faults beat illegal opcodes beat halt; only AOK can advance.
    always_comb begin
        statNext  = statR;
        weE       = 1'b0;
        weM       = 1'b0;
        incRetire = 1'b0;
        if ((statR == S_AOK) && instr_valid) begin
            if (imem_error || dmem_error) begin
                statNext = S_ADR;
            end else if (icode > I_POPQ) begin
                statNext = S_INS;
            end else if (icode == I_HALT) begin
                statNext  = S_HLT;
                incRetire = 1'b1;
            end else begin
                statNext  = S_AOK;
                weE       = (dstE != RNONE);
                weM       = (dstM != RNONE);
                incRetire = 1'b1;
            end
        end else begin
            statNext = statR;
        end
    end

    // Status register and retired counter; counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            statR    <= S_AOK;
            haltedR  <= 1'b0;
            retiredR <= {CW{1'b0}};
        end else begin
            statR   <= statNext;
            haltedR <= (statNext != S_AOK);
            if (incRetire) begin
                retiredR <= retiredR + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                retiredR <= retiredR;
            end
        end
    end

    assign stat    = statR;
    assign halted  = haltedR;
    assign retired = retiredR;

    y86_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .srcA (srcA),
        .srcB (srcB),
        .valA (valA),
        .valB (valB),
        .weE  (weE),
        .dstE (dstE),
        .valE (valE),
        .weM  (weM),
        .dstM (dstM),
        .valM (valM)
    );

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Directed bench for the write-back slice: an independent architectural
// model predicts each cycle, predictions are queued at drive time and popped
// for comparison one cycle later.
module tb_y86_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [3:0]  icode, ifun, rA, rB, srcA, srcB;
    logic        cnd, imem_error, dmem_error;
    logic [63:0] valE, valM, valA, valB;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  st;
        logic        h;
        logic [63:0] ret;
    } exp_t;

    exp_t expQ[$];

    logic [63:0] mReg [16];
    logic [2:0]  mStat;
    logic [63:0] mRet;

    always #20 clk = ~clk;

    y86_writeback_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .cnd         (cnd),
        .valE        (valE),
        .valM        (valM),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .stat        (stat),
        .halted      (halted),
        .retired     (retired)
    );

    function automatic logic [63:0] mRead(input logic [3:0] idx);
        return (idx == 4'hF) ? 64'h0 : mReg[idx];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one cycle, written from the ISA description.
    task automatic modelCycle(input logic r, input logic iv, input logic [3:0] ic,
                              input logic [3:0] a, input logic [3:0] b, input logic c,
                              input logic [63:0] e, input logic [63:0] m, input logic fault);
        if (r) begin
            for (int i = 0; i < 16; i++) mReg[i] = 64'h0;
            mStat = 3'd1;
            mRet  = 64'h0;
        end else if (mStat == 3'd1 && iv) begin
            if (fault) mStat = 3'd3;
            else if (ic >= 4'hC) mStat = 3'd4;
            else if (ic == 4'h0) begin
                mStat = 3'd2;
                mRet  = mRet + 64'd1;
            end else begin
                mRet = mRet + 64'd1;
                if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) mReg[b] = e;
                if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) mReg[4] = e;
                if (ic == 4'h5 || ic == 4'hB) if (a != 4'hF) mReg[a] = m;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic iv, input logic [3:0] ic,
                        input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [63:0] e, input logic [63:0] m,
                        input logic ie, input logic de,
                        input logic [3:0] sa, input logic [3:0] sb);
        exp_t x;
        exp_t got;
        rst = r; instr_valid = iv; icode = ic; ifun = 4'h0; rA = a; rB = b; cnd = c;
        valE = e; valM = m; imem_error = ie; dmem_error = de; srcA = sa; srcB = sb;
        modelCycle(r, iv, ic, a, b, c, e, m, ie | de);
        x.tag = tag; x.a = mRead(sa); x.b = mRead(sb);
        x.st = mStat; x.h = (mStat != 3'd1); x.ret = mRet;
        expQ.push_back(x);
        @(posedge clk);
        #1;
        compared++;
        assert (expQ.size() > 0) else begin
            mismatched++;
            $error("FAIL %s_queue: observed=0 entries expected=1", tag);
        end
        if (expQ.size() > 0) begin
            got = expQ.pop_front();
            check({got.tag, "_valA"}, valA, got.a);
            check({got.tag, "_valB"}, valB, got.b);
            check({got.tag, "_stat"}, {61'h0, stat}, {61'h0, got.st});
            check({got.tag, "_halted"}, {63'h0, halted}, {63'h0, got.h});
            check({got.tag, "_retired"}, retired, got.ret);
        end
    endtask

    // Walk every register through both read ports without crossing a clock edge.
    task automatic sweep(input string tag);
        for (int r = 0; r < 15; r++) begin
            srcA = 4'(r);
            srcB = 4'(14 - r);
            #1;
            check($sformatf("%s_rdA%0d", tag, r), valA, mRead(4'(r)));
            check($sformatf("%s_rdB%0d", tag, 14 - r), valB, mRead(4'(14 - r)));
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; icode = 4'h0; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
        cnd = 1'b0; valE = 64'h0; valM = 64'h0; imem_error = 1'b0; dmem_error = 1'b0;
        srcA = 4'hF; srcB = 4'hF;
        for (int i = 0; i < 16; i++) mReg[i] = 64'h0;
        mStat = 3'd1; mRet = 64'h0;

        //    tag          rst  iv  ic     rA     rB     cnd   valE          valM        ie    de    srcA   srcB
        step("reset",      1'b1,1'b0,4'h0, 4'hF, 4'hF, 1'b0, 64'h0,        64'h0,      1'b0, 1'b0, 4'h0, 4'h1);
        sweep("post_reset");
        step("irmovq",     1'b0,1'b1,4'h3, 4'hF, 4'h2, 1'b0, 64'h10,       64'h0,      1'b0, 1'b0, 4'h2, 4'hF);
        check("irmovq_const_valA", valA, 64'h10);
        check("irmovq_const_retired", retired, 64'd1);
        step("opq",        1'b0,1'b1,4'h6, 4'h2, 4'h5, 1'b0, 64'hAAAA,     64'h0,      1'b0, 1'b0, 4'h5, 4'h2);
        step("popq_rsp",   1'b0,1'b1,4'hB, 4'h4, 4'hF, 1'b0, 64'h100,      64'h55,     1'b0, 1'b0, 4'h4, 4'h5);
        check("popq_const_rsp", valA, 64'h55);
        step("pushq",      1'b0,1'b1,4'hA, 4'h5, 4'hF, 1'b0, 64'h200,      64'h0,      1'b0, 1'b0, 4'h4, 4'h3);
        step("mrmovq",     1'b0,1'b1,4'h5, 4'h7, 4'h4, 1'b0, 64'h999,      64'h1234,   1'b0, 1'b0, 4'h7, 4'h4);
        step("cmov_nt",    1'b0,1'b1,4'h2, 4'h5, 4'h3, 1'b0, 64'h7,        64'h0,      1'b0, 1'b0, 4'h3, 4'h5);
        check("cmov_nt_const", valA, 64'h0);
        step("cmov_t",     1'b0,1'b1,4'h2, 4'h5, 4'h3, 1'b1, 64'h8,        64'h0,      1'b0, 1'b0, 4'h3, 4'h4);
        step("call",       1'b0,1'b1,4'h8, 4'hF, 4'hF, 1'b0, 64'h1F8,      64'h0,      1'b0, 1'b0, 4'h4, 4'h7);
        step("ret",        1'b0,1'b1,4'h9, 4'hF, 4'hF, 1'b0, 64'h200,      64'h77,     1'b0, 1'b0, 4'h4, 4'h0);
        step("idle",       1'b0,1'b0,4'h3, 4'hF, 4'h0, 1'b0, 64'hFF,       64'hFF,     1'b0, 1'b0, 4'hF, 4'h0);
        check("rnone_const", valA, 64'h0);
        step("nop",        1'b0,1'b1,4'h1, 4'h0, 4'h0, 1'b0, 64'hDEAD,     64'hBEEF,   1'b0, 1'b0, 4'h0, 4'hF);
        step("rmmovq",     1'b0,1'b1,4'h4, 4'h1, 4'h2, 1'b0, 64'hCAFE,     64'hF00D,   1'b0, 1'b0, 4'h1, 4'h2);
        step("jxx",        1'b0,1'b1,4'h7, 4'h6, 4'h6, 1'b1, 64'h4000,     64'h0,      1'b0, 1'b0, 4'h6, 4'hE);
        step("irmovq_r14", 1'b0,1'b1,4'h3, 4'hF, 4'hE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0, 4'hE, 4'hF);
        sweep("mid_prog");
        step("halt",       1'b0,1'b1,4'h0, 4'hF, 4'hF, 1'b0, 64'h0,        64'h0,      1'b0, 1'b0, 4'h1, 4'h4);
        check("halt_const_stat", {61'h0, stat}, 64'd2);
        step("after_halt", 1'b0,1'b1,4'h6, 4'h0, 4'h1, 1'b0, 64'h9,        64'h0,      1'b0, 1'b0, 4'h1, 4'h4);
        step("halt_fault", 1'b0,1'b1,4'hD, 4'h0, 4'h1, 1'b0, 64'h9,        64'h0,      1'b0, 1'b1, 4'h1, 4'h4);
        sweep("halted");

        step("reset2",     1'b1,1'b1,4'h3, 4'hF, 4'h2, 1'b0, 64'h33,       64'h0,      1'b0, 1'b0, 4'h2, 4'h4);
        sweep("post_reset2");
        step("irmovq2",    1'b0,1'b1,4'h3, 4'hF, 4'h6, 1'b0, 64'h66,       64'h0,      1'b0, 1'b0, 4'h6, 4'hF);
        step("ins_dmem",   1'b0,1'b1,4'hD, 4'h6, 4'h6, 1'b0, 64'h1,        64'h2,      1'b0, 1'b1, 4'h6, 4'hF);
        check("fault_prio_const", {61'h0, stat}, 64'd3);
        step("after_adr",  1'b0,1'b1,4'h3, 4'hF, 4'h6, 1'b0, 64'h77,       64'h0,      1'b0, 1'b0, 4'h6, 4'hF);
        step("reset3",     1'b1,1'b0,4'h0, 4'hF, 4'hF, 1'b0, 64'h0,        64'h0,      1'b0, 1'b0, 4'h6, 4'hF);
        check("reset3_const_retired", retired, 64'd0);
        step("imem_fault", 1'b0,1'b1,4'h3, 4'hF, 4'h1, 1'b0, 64'h11,       64'h0,      1'b1, 1'b0, 4'h1, 4'hF);
        step("reset4",     1'b1,1'b0,4'h0, 4'hF, 4'hF, 1'b0, 64'h0,        64'h0,      1'b0, 1'b0, 4'h1, 4'hF);
        step("popq_r8",    1'b0,1'b1,4'hB, 4'h8, 4'hF, 1'b0, 64'h108,      64'h88,     1'b0, 1'b0, 4'h8, 4'h4);
        step("ins_C",      1'b0,1'b1,4'hC, 4'h8, 4'h8, 1'b0, 64'h1,        64'h2,      1'b0, 1'b0, 4'h8, 4'h4);
        check("ins_const_stat", {61'h0, stat}, 64'd4);
        step("after_ins",  1'b0,1'b1,4'hB, 4'h8, 4'hF, 1'b0, 64'h5,        64'h6,      1'b0, 1'b0, 4'h8, 4'h4);
        step("reset5",     1'b1,1'b1,4'h0, 4'hF, 4'hF, 1'b0, 64'h0,        64'h0,      1'b0, 1'b0, 4'h8, 4'h4);
        sweep("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/y86_writeback_regfile.md
Name: y86_writeback_regfile

Overview:
- Write-back end of the sequential Y86-64 datapath: consumes the Memory stage's valM together with Execute's valE and commits them to the 15-entry register file.
- Also owns architectural status (AOK/HLT/ADR/INS) and a retired-instruction counter.
- Provides the combinational register read ports used by Decode.
- Sits after the Memory stage; its outputs close the loop back to Decode and to PC-update/halt control.

Parameters:
- NREG, 15, architectural registers (IDs 0x0-0xE; 0xF = RNONE).
- DW, 64, data width.
- CW, 64, retired-counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  an instruction completes this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code; informational only.
- rA  in  4  register field A.
- rB  in  4  register field B.
- cnd  in  1  condition result from Execute; used by cmovXX.
- valE  in  DW  Execute result.
- valM  in  DW  Memory read data.
- imem_error  in  1  fetch address fault.
- dmem_error  in  1  data memory address fault.
- srcA  in  4  read port A address.
- srcB  in  4  read port B address.
- valA  out  DW  reg[srcA]; 0 if srcA = 0xF.
- valB  out  DW  reg[srcB]; 0 if srcB = 0xF.
- stat  out  3  1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- halted  out  1  high whenever stat != AOK.
- retired  out  CW  count of committed instructions.

Behaviour:
- Reset (rst = 1 at rising clk): all registers := 0, stat := AOK, retired := 0. Reset takes precedence over any write in the same cycle, including a reset asserted mid-program.
- Read ports are combinational. A write on an edge is visible on valA/valB only after that edge; there is no write-through bypass.
- dstE:
  - icode 2 (cmovXX): rB if cnd, else RNONE.
  - icode 3 (irmovq) and 6 (OPq): rB.
  - icode 8/9/A/B (call/ret/push/pop): RSP (0x4).
  - Otherwise: RNONE.
- dstM: rA for icode 5 (mrmovq) and B (popq); otherwise RNONE.
- Status FSM, state = stat; only AOK advances. In AOK with instr_valid = 1, evaluate in priority order:
  1. imem_error or dmem_error → ADR; no register write; retired unchanged.
  2. icode > 0xB → INS; no write; retired unchanged.
  3. icode = 0 (halt) → HLT; retired += 1; no register write.
  4. Otherwise: reg[dstE] := valE if dstE != RNONE; reg[dstM] := valM if dstM != RNONE; retired += 1; stat stays AOK.
- In AOK with instr_valid = 0: no state change.
- HLT, ADR and INS are sticky until rst. In these states all writes and the counter are frozen regardless of inputs.
- Simultaneous write to the same register (popq %rsp, dstE = dstM = 4): valM wins.
- retired wraps modulo 2^CW with no saturation.
- Latency: one cycle from instr_valid to committed state.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT … I_POPQ).
  - RNONE = 4'hF, RSP = 4'h4.
  - stat encodings S_AOK/S_HLT/S_ADR/S_INS.
- Natural sub-module: y86_regfile, a 15×64 storage array with two combinational read ports and two synchronous write ports (E and M, M has priority), plus synchronous reset.
- Top level holds dst computation, status FSM and counter.

Test Plan:
- Reset then commit: rst pulse; irmovq (icode 3, rB = 2, valE = 0x10) → next cycle srcA = 2 gives valA = 0x10, retired = 1, stat = 1.
- popq %rsp: icode B, rA = 4, valE = 0x100, valM = 0x55 → reg[4] = 0x55, retired increments by 1.
- cmov not taken: icode 2, rB = 3, cnd = 0, valE = 0x7 → reg[3] unchanged; retired still increments.
- Halt stickiness: icode 0 → stat = 2, halted = 1; then an OPq writing rB = 1 with valE = 0x9 → reg[1] unchanged, retired frozen.
- Fault priority: icode 0xD with dmem_error = 1 → stat = 3 (ADR), not INS; no write. Then rst → stat = 1, all regs 0, retired 0.
- Read of RNONE and idle cycle: srcA = 0xF → valA = 0; instr_valid = 0 with valE = 0xFF → no change to any state.
